// File: rtl/dmem_responder.sv
// Data-memory responder: captures one byte-masked load/store, waits LATENCY cycles,
// performs the access on an internal word array and answers with a one-cycle pulse.
module dmem_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        dmem_err,
    output logic [1:0]  o_dbg_state
);

    // Handshake: a request is present while either mask is nonzero. The initiator
    // holds it stable until it samples dmem_resp=1 (a single-cycle pulse) and drops
    // it the following cycle, which DONE absorbs before the next capture.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int         DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic        w_req;
    logic        w_capture;
    logic        w_access;

    logic [29:0] r_addr;
    logic [3:0]  r_rmask;
    logic [3:0]  r_wmask;
    logic [31:0] r_wdata;

    logic [29:0] w_src_addr;
    logic [3:0]  w_src_rmask;
    logic [3:0]  w_src_wmask;
    logic [31:0] w_src_wdata;
    logic [29:0] w_off;
    logic        w_in_range;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [31:0] w_word;
    logic [31:0] w_read;
    logic        w_both;

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;
    logic        r_resp;
    logic        r_err;

    logic        w_unused_addr_bits;
    assign w_unused_addr_bits = ^dmem_addr[1:0];

    assign w_req = (|dmem_rmask) | (|dmem_wmask);

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_capture  = 1'b0;
        w_access   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_capture = 1'b1;
                    if (LATENCY == 1) begin
                        w_access   = 1'b1;
                        w_next     = S_RESP;
                        w_cnt_next = 4'd0;
                    end else begin
                        w_next     = S_WAIT;
                        w_cnt_next = LAT_M1;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_access = 1'b1;
                    w_next   = S_RESP;
                end
            end
            S_RESP:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // With LATENCY==1 the access happens on the capture edge, so the live inputs
    // stand in for the not-yet-loaded capture registers.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_src_addr  = dmem_addr[31:2];
            w_src_rmask = dmem_rmask;
            w_src_wmask = dmem_wmask;
            w_src_wdata = dmem_wdata;
        end else begin
            w_src_addr  = r_addr;
            w_src_rmask = r_rmask;
            w_src_wmask = r_wmask;
            w_src_wdata = r_wdata;
        end
    end

    // Word-granular offset; an address below the base wraps high and lands out of range.
    assign w_off      = w_src_addr - BASE_ADDR[31:2];
    assign w_in_range = (w_off >> DEPTH_LOG2) == 30'd0;
    assign w_idx      = w_off[DEPTH_LOG2-1:0];
    assign w_word     = r_mem[w_idx];
    assign w_both     = (|w_src_rmask) & (|w_src_wmask);

    always_comb begin
        w_read = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (w_src_rmask[i]) w_read[i*8 +: 8] = w_word[i*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_resp  <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
            r_addr  <= 30'd0;
            r_rmask <= 4'd0;
            r_wmask <= 4'd0;
            r_wdata <= 32'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_resp  <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'd0;
            if (w_capture) begin
                r_addr  <= dmem_addr[31:2];
                r_rmask <= dmem_rmask;
                r_wmask <= dmem_wmask;
                r_wdata <= dmem_wdata;
            end
            if (w_access) begin
                r_resp <= 1'b1;
                if (!w_in_range || w_both) begin
                    r_err <= 1'b1;
                end else begin
                    r_rdata <= w_read;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_access && w_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (w_src_wmask[i]) r_mem[w_idx][i*8 +: 8] <= w_src_wdata[i*8 +: 8];
            end
        end
    end

    assign dmem_rdata  = r_rdata;
    assign dmem_resp   = r_resp;
    assign dmem_err    = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2/base-0 instance and a LATENCY=1/offset-base
// instance, driven with directed and random requests and checked by a scoreboard.
module tb_dmem_responder;

    localparam int          L0 = 2;
    localparam int          L1 = 1;
    localparam logic [31:0] B1 = 32'h0000_0400;
    localparam int          DEP0 = 1024;
    localparam int          DEP1 = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst   [2];
    logic [31:0] addr  [2];
    logic [3:0]  rmask [2];
    logic [3:0]  wmask [2];
    logic [31:0] wdata [2];

    logic [31:0] rdata0, rdata1;
    logic        resp0, resp1, err0, err1;
    logic [1:0]  dbg0, dbg1;

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(L0), .BASE_ADDR(32'h0)) u_dut0 (
        .clk(clk), .rst(rst[0]), .dmem_addr(addr[0]), .dmem_rmask(rmask[0]),
        .dmem_wmask(wmask[0]), .dmem_wdata(wdata[0]), .dmem_rdata(rdata0),
        .dmem_resp(resp0), .dmem_err(err0), .o_dbg_state(dbg0)
    );

    dmem_responder #(.DEPTH_LOG2(6), .LATENCY(L1), .BASE_ADDR(B1)) u_dut1 (
        .clk(clk), .rst(rst[1]), .dmem_addr(addr[1]), .dmem_rmask(rmask[1]),
        .dmem_wmask(wmask[1]), .dmem_wdata(wdata[1]), .dmem_rdata(rdata1),
        .dmem_resp(resp1), .dmem_err(err1), .o_dbg_state(dbg1)
    );

    int checks = 0;
    int errors = 0;

    // Scoreboard entries: {response cycle[31:0], err, rdata[31:0]}
    logic [64:0] exp_q0[$];
    logic [64:0] exp_q1[$];

    // Reference memory contents, keyed by word index
    logic [31:0] mem0[int];
    logic [31:0] mem1[int];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural model: a request either errors out or reads the old word and
    // merges the written lanes, all from the byte-lane rules.
    function automatic void model(input int d, input logic [31:0] a, input logic [3:0] rm,
                                  input logic [3:0] wm, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic e);
        logic [31:0] base, off, old, nw;
        int unsigned depth, idx;
        base  = (d == 0) ? 32'h0 : B1;
        depth = (d == 0) ? DEP0 : DEP1;
        off   = {a[31:2], 2'b00} - base;
        idx   = off / 4;
        rd = 32'd0;
        e  = 1'b0;
        if (idx >= depth) begin
            e = 1'b1;
            return;
        end
        old = 32'd0;
        if (d == 0 && mem0.exists(int'(idx))) old = mem0[int'(idx)];
        if (d == 1 && mem1.exists(int'(idx))) old = mem1[int'(idx)];
        nw = old;
        for (int i = 0; i < 4; i++) begin
            if (wm[i]) nw[i*8 +: 8] = wd[i*8 +: 8];
            if (rm[i]) rd[i*8 +: 8] = old[i*8 +: 8];
        end
        if (rm != 4'd0 && wm != 4'd0) begin
            rd = 32'd0;
            e  = 1'b1;
        end
        if (wm != 4'd0) begin
            if (d == 0) mem0[int'(idx)] = nw;
            else        mem1[int'(idx)] = nw;
        end
    endfunction

    function automatic logic resp_of(input int d);
        return (d == 0) ? resp0 : resp1;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? L0 : L1;
    endfunction

    task automatic push_exp(input int d, input int c, input logic e, input logic [31:0] rd);
        if (d == 0) exp_q0.push_back({32'(c), e, rd});
        else        exp_q1.push_back({32'(c), e, rd});
    endtask

    // Driver: issue one request on a falling edge (DUT idle), hold it until the
    // response is seen, drop it, then step past the turnaround cycle.
    task automatic req(input int d, input logic [31:0] a, input logic [3:0] rm,
                       input logic [3:0] wm, input logic [31:0] wd);
        logic [31:0] erd;
        logic        ee;
        int          n;
        model(d, a, rm, wm, wd, erd, ee);
        @(negedge clk);
        addr[d] = a; rmask[d] = rm; wmask[d] = wm; wdata[d] = wd;
        push_exp(d, cyc + lat_of(d), ee, erd);
        n = 0;
        while (!resp_of(d) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout dut%0d: no response within 40 cycles, required one", d);
        end
        rmask[d] = 4'd0; wmask[d] = 4'd0;
        @(negedge clk);
    endtask

    // A load held through two service windows, with glitched inputs while waiting.
    task automatic hold_load(input logic [31:0] a);
        logic [31:0] erd;
        logic        ee;
        int          c;
        model(0, a, 4'hF, 4'h0, 32'h0, erd, ee);
        @(negedge clk);
        c = cyc;
        addr[0] = a; rmask[0] = 4'hF; wmask[0] = 4'h0; wdata[0] = 32'h0;
        push_exp(0, c + L0, ee, erd);
        push_exp(0, c + 2 * L0 + 2, ee, erd);
        @(negedge clk);
        addr[0] = a ^ 32'h40; rmask[0] = 4'b0001; wmask[0] = 4'hF; wdata[0] = $urandom();
        @(negedge clk);
        addr[0] = a; rmask[0] = 4'hF; wmask[0] = 4'h0;
        while (cyc < c + 2 * L0 + 3) @(negedge clk);
        rmask[0] = 4'd0;
    endtask

    // Store abandoned by reset while waiting: no response, no write.
    task automatic reset_mid_store(input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        addr[0] = a; rmask[0] = 4'h0; wmask[0] = 4'hF; wdata[0] = wd;
        @(negedge clk);
        rst[0] = 1'b0;
        rmask[0] = 4'h0; wmask[0] = 4'h0;
        @(negedge clk);
        chk("reset_mid_resp", 32'(resp0), 32'd0);
        chk("reset_mid_rdata", rdata0, 32'd0);
        rst[0] = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [31:0] slot_addr(input int d, input int k);
        int depth;
        logic [31:0] base;
        depth = (d == 0) ? DEP0 : DEP1;
        base  = (d == 0) ? 32'h100 : B1;
        if (d == 1) return base + 32'(4 * ((k == 7) ? depth - 1 : k + 8));
        return base + 32'(4 * k);
    endfunction

    task automatic rand_run(input int d, input int n);
        logic [31:0] a;
        logic [3:0]  rm, wm;
        for (int k = 0; k < 8; k++) req(d, slot_addr(d, k), 4'h0, 4'hF, $urandom());
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                if (d == 0) a = 32'h1000 + 32'(4 * $urandom_range(0, 3));
                else        a = ($urandom_range(0, 1) == 0) ? B1 - 32'd4 : B1 + 32'h100;
            end else begin
                a = slot_addr(d, int'($urandom_range(0, 7)));
            end
            a = a | 32'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       begin rm = 4'($urandom_range(1, 15)); wm = 4'h0; end
                1:       begin rm = 4'h0; wm = 4'($urandom_range(1, 15)); end
                2:       begin rm = 4'($urandom_range(0, 15)); wm = 4'h0; end
                default: begin rm = 4'($urandom_range(1, 15)); wm = 4'($urandom_range(1, 15)); end
            endcase
            if (rm == 4'h0 && wm == 4'h0) rm = 4'hF;
            req(d, a, rm, wm, $urandom());
        end
    endtask

    task automatic mon(input int d, input logic [31:0] rd, input logic e);
        logic [64:0] x;
        int sz;
        sz = (d == 0) ? exp_q0.size() : exp_q1.size();
        if (sz == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp dut%0d: resp=1 at cycle %0d, expected no response", d, cyc);
            return;
        end
        if (d == 0) x = exp_q0.pop_front();
        else        x = exp_q1.pop_front();
        chk($sformatf("resp_cycle_dut%0d", d), 32'(cyc), x[64:33]);
        chk($sformatf("err_dut%0d", d), 32'(e), 32'(x[32]));
        chk($sformatf("rdata_dut%0d", d), rd, x[31:0]);
    endtask

    always @(negedge clk) begin
        if (resp0 === 1'b1) mon(0, rdata0, err0);
        if (resp1 === 1'b1) mon(1, rdata1, err1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0; addr[d] = 32'h0; rmask[d] = 4'h0; wmask[d] = 4'h0; wdata[d] = 32'h0;
        end
        repeat (3) @(negedge clk);
        chk("reset_resp0", 32'(resp0), 32'd0);
        chk("reset_err0", 32'(err0), 32'd0);
        chk("reset_rdata0", rdata0, 32'd0);
        chk("reset_resp1", 32'(resp1), 32'd0);
        chk("reset_err1", 32'(err1), 32'd0);
        chk("reset_rdata1", rdata1, 32'd0);
        rst[0] = 1'b1;
        rst[1] = 1'b1;

        // Full-word store and readback
        req(0, 32'h10, 4'h0, 4'hF, 32'hDEAD_BEEF);
        req(0, 32'h10, 4'hF, 4'h0, 32'h0);
        // Byte-lane write and masked reads
        req(0, 32'h10, 4'h0, 4'b1000, 32'hAB00_0000);
        req(0, 32'h10, 4'b0010, 4'h0, 32'h0);
        req(0, 32'h10, 4'b1100, 4'h0, 32'h0);
        // Held request, serviced twice; glitches while waiting are ignored
        hold_load(32'h10);
        // Reset abandons a pending store
        req(0, 32'h20, 4'h0, 4'hF, 32'h1111_1111);
        reset_mid_store(32'h20, 32'h1234_5678);
        req(0, 32'h20, 4'hF, 4'h0, 32'h0);
        req(0, 32'h10, 4'hF, 4'h0, 32'h0);
        // Out of range, no aliasing onto word 0, and both-masks error with write
        req(0, 32'h0, 4'h0, 4'hF, 32'hCAFE_F00D);
        req(0, 32'h0000_1000, 4'h0, 4'hF, 32'h5A5A_5A5A);
        req(0, 32'h0, 4'hF, 4'h0, 32'h0);
        req(0, 32'h10, 4'hF, 4'b0011, 32'h0000_5555);
        req(0, 32'h10, 4'hF, 4'h0, 32'h0);

        // Single-cycle latency instance with an offset base: back-to-back spacing 3
        req(1, B1, 4'h0, 4'hF, 32'h0102_0304);
        req(1, B1 + 32'h4, 4'h0, 4'hF, 32'hA5A5_0000);
        req(1, B1, 4'hF, 4'h0, 32'h0);
        req(1, B1 + 32'hFC, 4'h0, 4'hF, 32'h7777_8888);
        req(1, B1 + 32'hFC, 4'b0101, 4'h0, 32'h0);
        req(1, B1 - 32'h4, 4'h0, 4'hF, 32'hFFFF_FFFF);
        req(1, B1 + 32'h100, 4'hF, 4'h0, 32'h0);
        req(1, B1 + 32'h4, 4'hF, 4'h0, 32'h0);

        rand_run(0, 60);
        rand_run(1, 60);

        repeat (6) @(negedge clk);
        chk("exp_q0_drained", 32'(exp_q0.size()), 32'd0);
        chk("exp_q1_drained", 32'(exp_q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
